// File: rtl/ldpc_pkg.sv
// Shared types and width helpers for the LDPC codeword assembler.
package ldpc_pkg;

  typedef enum logic {
    SYS = 1'b0,
    PAR = 1'b1
  } state_e;

  // Word counter width: covers max(K_WORDS, P_WORDS) - 1, at least one bit.
  function automatic int unsigned cnt_width(input int unsigned k_words, input int unsigned p_words);
    int unsigned m;
    m = (k_words > p_words) ? k_words : p_words;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // FIFO pointer width: address bits plus one wrap bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ldpc_codeword_assembler_fifo.sv
// Parity FIFO: synchronous, wrap-bit pointers, cleared by synchronous reset.
module ldpc_parity_fifo
  import ldpc_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PAR_DEPTH = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = ptr_width(PAR_DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [PAR_DEPTH];
  logic             do_push, do_pop;

  // Full when addresses match but wrap bits differ.
  always_comb begin
    full_o  = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    empty_o = (wr_q == rd_q);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wr_d    = wr_q + PW'(do_push);
    rd_d    = rd_q + PW'(do_pop);
    data_o  = mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (do_push && !reset_i) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/ldpc_codeword_assembler.sv
// Merges systematic and parity words into framed codewords on a valid/ready output.
// Optional CODEWORD_ASSEMBLER_PUNCTURE_EN drops the first PUNCT_WORDS systematic words.
module ldpc_codeword_assembler
  import ldpc_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned K_WORDS     = 16,
  parameter int unsigned P_WORDS     = 8,
  parameter int unsigned PAR_DEPTH   = 16,
  parameter int unsigned PUNCT_WORDS = 2
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_sys_data,
  input  logic             i_sys_valid,
  output logic             o_sys_ready,
  input  logic [WIDTH-1:0] i_par_data,
  input  logic             i_par_valid,
  output logic             o_par_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  output logic             o_out_last,
  input  logic             i_out_ready,
  output logic             o_overflow
);

  localparam int unsigned     CW     = cnt_width(K_WORDS, P_WORDS);
  localparam logic [CW-1:0]   K_LAST = CW'(K_WORDS - 1);
  localparam logic [CW-1:0]   P_LAST = CW'(P_WORDS - 1);

  if (PUNCT_WORDS >= K_WORDS || PAR_DEPTH < P_WORDS || K_WORDS < 1) begin : g_bad_cfg
    $error("ldpc_codeword_assembler: invalid parameter set");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             ovf_q, ovf_d;

  logic             load_c, punct_c, sys_rdy_c, sys_xfer_c, pop_c;
  logic             fifo_full, fifo_empty;
  logic [WIDTH-1:0] fifo_head;

  ldpc_parity_fifo #(
    .WIDTH     (WIDTH),
    .PAR_DEPTH (PAR_DEPTH)
  ) u_par_fifo (
    .clock_i (i_clock),
    .reset_i (i_reset),
    .push_i  (i_par_valid),
    .data_i  (i_par_data),
    .pop_i   (pop_c),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Handshakes, next state and output register load.
  always_comb begin
    punct_c = 1'b0;
`ifdef CODEWORD_ASSEMBLER_PUNCTURE_EN
    punct_c = (state_q == SYS) && (cnt_q < CW'(PUNCT_WORDS));
`endif
    load_c     = !valid_q || i_out_ready;
    sys_rdy_c  = !i_reset && (state_q == SYS) && (load_c || punct_c);
    sys_xfer_c = sys_rdy_c && i_sys_valid;
    pop_c      = !i_reset && (state_q == PAR) && load_c && !fifo_empty;

    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    ovf_d   = ovf_q || (i_par_valid && fifo_full);

    // An accepted (or empty) output register drains unless reloaded below.
    if (load_c) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    if (sys_xfer_c) begin
      if (!punct_c) begin
        data_d  = i_sys_data;
        valid_d = 1'b1;
        last_d  = 1'b0;
      end
      if (cnt_q == K_LAST) begin
        cnt_d   = '0;
        state_d = PAR;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (pop_c) begin
      data_d  = fifo_head;
      valid_d = 1'b1;
      last_d  = (cnt_q == P_LAST);
      if (cnt_q == P_LAST) begin
        cnt_d   = '0;
        state_d = SYS;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= SYS;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_sys_ready = sys_rdy_c;
  assign o_par_ready = !i_reset && !fifo_full;
  assign o_out_data  = data_q;
  assign o_out_valid = valid_q;
  assign o_out_last  = last_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_ldpc_codeword_assembler.sv
// Self-checking bench for ldpc_codeword_assembler: codeword-level scoreboard plus directed literals.
module tb_ldpc_codeword_assembler;

  localparam int W  = 8;
  localparam int K  = 16;
  localparam int P  = 8;
  localparam int D  = 16;
  localparam int PU = 2;
`ifdef CODEWORD_ASSEMBLER_PUNCTURE_EN
  localparam int PE = PU;
`else
  localparam int PE = 0;
`endif
  localparam int L  = K - PE + P;

  logic         i_clock;
  logic         i_reset;
  logic [W-1:0] i_sys_data;
  logic         i_sys_valid;
  logic         o_sys_ready;
  logic [W-1:0] i_par_data;
  logic         i_par_valid;
  logic         o_par_ready;
  logic [W-1:0] o_out_data;
  logic         o_out_valid;
  logic         o_out_last;
  logic         i_out_ready;
  logic         o_overflow;

  int tests = 0;
  int fails = 0;

  // Model state: words owed to the output, in codeword order.
  logic [W-1:0] sysq[$];
  logic [W-1:0] parq[$];
  logic [W-1:0] got[$];
  int           gotc[$];
  int           pos = 0;
  int           sys_idx = 0;
  int           cyc = 0;
  logic         ovf_exp = 1'b0;
  logic         par_drop = 1'b0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic         prev_last = 1'b0;

  ldpc_codeword_assembler #(
    .WIDTH       (W),
    .K_WORDS     (K),
    .P_WORDS     (P),
    .PAR_DEPTH   (D),
    .PUNCT_WORDS (PU)
  ) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_sys_data  (i_sys_data),
    .i_sys_valid (i_sys_valid),
    .o_sys_ready (o_sys_ready),
    .i_par_data  (i_par_data),
    .i_par_valid (i_par_valid),
    .o_par_ready (o_par_ready),
    .o_out_data  (o_out_data),
    .o_out_valid (o_out_valid),
    .o_out_last  (o_out_last),
    .i_out_ready (i_out_ready),
    .o_overflow  (o_overflow)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Observes handshakes at negedge and checks every output transfer against the model.
  task automatic monitor();
    logic [W-1:0] ed;
    logic         el;
    forever begin
      @(negedge i_clock);
      cyc++;
      if (i_reset) begin
        sysq.delete();
        parq.delete();
        pos        = 0;
        sys_idx    = 0;
        ovf_exp    = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 32'(o_out_valid), 32'd1);
          chk("stall_data", 32'(o_out_data), 32'(prev_data));
          chk("stall_last", 32'(o_out_last), 32'(prev_last));
        end
        chk("overflow", 32'(o_overflow), 32'(ovf_exp));
        if (o_out_valid && i_out_ready) begin
          if ((pos < K - PE && sysq.size() == 0) || (pos >= K - PE && parq.size() == 0)) begin
            tests++;
            fails++;
            $display("FAIL extra_word: got %0h at position %0d, expected no word", o_out_data, pos);
          end else begin
            if (pos < K - PE) begin
              ed = sysq.pop_front();
              el = 1'b0;
            end else begin
              ed = parq.pop_front();
              el = (pos == L - 1);
            end
            chk("out_data", 32'(o_out_data), 32'(ed));
            chk("out_last", 32'(o_out_last), 32'(el));
          end
          pos = (pos + 1) % L;
          got.push_back(o_out_data);
          gotc.push_back(cyc);
        end
        prev_stall = o_out_valid && !i_out_ready;
        prev_data  = o_out_data;
        prev_last  = o_out_last;
        if (i_sys_valid && o_sys_ready) begin
          if (sys_idx >= PE) sysq.push_back(i_sys_data);
          sys_idx = (sys_idx + 1) % K;
        end
        if (i_par_valid) begin
          if (par_drop) ovf_exp = 1'b1;
          else parq.push_back(i_par_data);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic drive_sys(input logic [W-1:0] base, input int n);
    int   i = 0;
    int   g = 0;
    logic acc;
    while (i < n && g < 2000) begin
      i_sys_data  = base + W'(i);
      i_sys_valid = 1'b1;
      @(negedge i_clock);
      acc = o_sys_ready;
      tick();
      if (acc) i++;
      g++;
    end
    i_sys_valid = 1'b0;
    chk("sys_accepted", 32'(i), 32'(n));
  endtask

  task automatic push_par(input logic [W-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      i_par_data  = base + W'(i);
      i_par_valid = 1'b1;
      tick();
    end
    i_par_valid = 1'b0;
  endtask

  task automatic basic_cw(input logic [W-1:0] sb, input logic [W-1:0] pb, input int dly);
    fork
      drive_sys(sb, K);
      begin
        repeat (dly) tick();
        push_par(pb, P);
      end
    join
  endtask

  task automatic wait_out(input int base, input int n, input string name);
    int g = 0;
    while (got.size() < base + n && g < 1000) begin
      tick();
      g++;
    end
    repeat (4) tick();
    chk({name, "_count"}, 32'(got.size() - base), 32'(n));
  endtask

  initial begin : main
    int   b;
    int   i;
    int   g;
    int   j;
    logic acc;

    i_reset     = 1'b1;
    i_sys_data  = '0;
    i_sys_valid = 1'b0;
    i_par_data  = '0;
    i_par_valid = 1'b0;
    i_out_ready = 1'b1;
    fork
      monitor();
      begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
      end
    join_none

    // Reset values.
    tick();
    @(negedge i_clock);
    chk("rst_sys_ready", 32'(o_sys_ready), 32'd0);
    chk("rst_par_ready", 32'(o_par_ready), 32'd0);
    tick();
    i_reset = 1'b0;
    @(negedge i_clock);
    chk("rst_valid", 32'(o_out_valid), 32'd0);
    chk("rst_last", 32'(o_out_last), 32'd0);
    chk("rst_data", 32'(o_out_data), 32'd0);
    chk("rst_overflow", 32'(o_overflow), 32'd0);
    chk("idle_par_ready", 32'(o_par_ready), 32'd1);
    tick();

    // Basic codeword.
    b = got.size();
    basic_cw(8'h00, 8'hA0, 3);
    wait_out(b, L, "basic");
    if (got.size() >= b + L) begin
      chk("basic_first", 32'(got[b]), 32'(PE));
      chk("basic_final", 32'(got[b+L-1]), 32'h0A7);
    end

    // Backpressure with ready pattern 1,0,0,1.
    b = got.size();
    fork
      basic_cw(8'h00, 8'hA0, 3);
      begin
        j = 0;
        while (got.size() < b + L && j < 2000) begin
          i_out_ready = (j % 4 == 0) || (j % 4 == 3);
          tick();
          j++;
        end
        i_out_ready = 1'b1;
      end
    join
    wait_out(b, L, "bp");
    if (got.size() >= b + L) chk("bp_final", 32'(got[b+L-1]), 32'h0A7);

    // Parity arrives before any systematic word.
    b = got.size();
    for (int k = 0; k < P; k++) begin
      i_par_data  = 8'hC0 + W'(k);
      i_par_valid = 1'b1;
      @(negedge i_clock);
      chk("early_par_ready", 32'(o_par_ready), 32'd1);
      tick();
    end
    i_par_valid = 1'b0;
    drive_sys(8'h30, K);
    wait_out(b, L, "early");
    if (got.size() >= b + L) begin
      chk("early_first_par", 32'(got[b+K-PE]), 32'h0C0);
      chk("early_no_bubble", 32'(gotc[b+L-1] - gotc[b]), 32'(L - 1));
    end

    // Overflow: D+1 parity words with the output stalled.
    b = got.size();
    i_out_ready = 1'b0;
    push_par(8'hB0, D);
    i_par_data  = 8'hC0;
    i_par_valid = 1'b1;
    par_drop    = 1'b1;
    @(negedge i_clock);
    chk("full_par_ready", 32'(o_par_ready), 32'd0);
    tick();
    i_par_valid = 1'b0;
    par_drop    = 1'b0;
    @(negedge i_clock);
    chk("ovf_set", 32'(o_overflow), 32'd1);
    tick();
    i_out_ready = 1'b1;
    drive_sys(8'h10, K);
    drive_sys(8'h20, K);
    wait_out(b, 2 * L, "ovf");
    if (got.size() >= b + 2 * L) begin
      chk("ovf_cw0_final", 32'(got[b+L-1]), 32'h0B7);
      chk("ovf_cw1_final", 32'(got[b+2*L-1]), 32'h0BF);
    end
    chk("ovf_sticky", 32'(o_overflow), 32'd1);

    // Reset after five output words.
    b = got.size();
    i = 0;
    g = 0;
    while (got.size() < b + 5 && g < 200) begin
      i_sys_data  = W'(i);
      i_sys_valid = 1'b1;
      @(negedge i_clock);
      acc = o_sys_ready;
      tick();
      if (acc) i++;
      g++;
    end
    i_sys_valid = 1'b0;
    i_reset     = 1'b1;
    chk("mid_count", 32'(got.size() - b), 32'd5);
    @(negedge i_clock);
    chk("mid_rst_sys_ready", 32'(o_sys_ready), 32'd0);
    tick();
    i_reset = 1'b0;
    @(negedge i_clock);
    chk("mid_rst_valid", 32'(o_out_valid), 32'd0);
    chk("mid_rst_last", 32'(o_out_last), 32'd0);
    chk("mid_rst_data", 32'(o_out_data), 32'd0);
    chk("mid_rst_overflow", 32'(o_overflow), 32'd0);
    tick();
    b = got.size();
    basic_cw(8'h00, 8'hA0, 3);
    wait_out(b, L, "fresh");
    if (got.size() >= b + L) begin
      chk("fresh_first", 32'(got[b]), 32'(PE));
      chk("fresh_final", 32'(got[b+L-1]), 32'h0A7);
    end

    chk("model_sys_drained", 32'(sysq.size()), 32'd0);
    chk("model_par_drained", 32'(parq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
